// File: rtl/fft_pkg.sv
// Shared defaults, state type and width helpers for the FFT twiddle/address sequencer.
// FFT_TW_QUARTER_EN selects a quarter-wave twiddle ROM: tw_addr narrows and tw_swap/tw_neg appear.
package fft_pkg;

  localparam int LOG2N_DEFAULT    = 10;
  localparam int BFLY_LAT_DEFAULT = 4;
  localparam int STAGE_W          = $clog2(LOG2N_DEFAULT);
  localparam int NBF              = 2 ** (LOG2N_DEFAULT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } seq_state_t;

  // Twiddle ROM address width: half-wave table by default, quarter-wave when folded.
  function automatic int tw_width(input int log2n);
`ifdef FFT_TW_QUARTER_EN
    return log2n - 2;
`else
    return log2n - 1;
`endif
  endfunction

endpackage

// File: rtl/fft_bf_addr_calc.sv
// Combinational (stage, butterfly index) -> operand/twiddle address mapper for radix-2 DIT.
// With FFT_TW_QUARTER_EN the twiddle index is folded onto a quarter-wave table.
module fft_bf_addr_calc
  import fft_pkg::*;
#(
  parameter int  LOG2N = LOG2N_DEFAULT,
  localparam int SW    = $clog2(LOG2N),
  localparam int TW_W  = tw_width(LOG2N)
) (
  input  logic [SW-1:0]    s,
  input  logic [LOG2N-2:0] j,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
`ifdef FFT_TW_QUARTER_EN
  output logic             tw_swap,
  output logic             tw_neg,
`endif
  output logic [TW_W-1:0]  tw_addr
);

  logic [LOG2N-2:0] mask;
  logic [LOG2N-2:0] k;
  logic [LOG2N-2:0] grp;
  logic [LOG2N-2:0] t;
  logic [LOG2N-1:0] half;

  // k selects the element inside a group of 2*half, grp selects the group.
  always_comb begin
    mask   = {(LOG2N-1){1'b1}} >> (LOG2N - 1 - int'(s));
    k      = j & mask;
    grp    = j >> s;
    half   = {{(LOG2N-1){1'b0}}, 1'b1} << s;
    addr_a = ({1'b0, grp} << (int'(s) + 1)) | {1'b0, k};
    addr_b = addr_a + half;
    t      = k << (LOG2N - 1 - int'(s));
  end

`ifdef FFT_TW_QUARTER_EN
  // Second quarter of the half wave is the first quarter rotated by -j.
  assign tw_swap = t[LOG2N-2];
  assign tw_neg  = t[LOG2N-2];
  assign tw_addr = t[LOG2N-3:0];
`else
  assign tw_addr = t;
`endif

endmodule

// File: rtl/fft_twiddle_sequencer.sv
// Stage-by-stage address sequencer for an in-place radix-2 DIT FFT with a drain gap per stage.
// Build option FFT_TW_QUARTER_EN: quarter-wave twiddle addressing with tw_swap/tw_neg outputs.
module fft_twiddle_sequencer
  import fft_pkg::*;
#(
  parameter int  LOG2N    = LOG2N_DEFAULT,
  parameter int  BFLY_LAT = BFLY_LAT_DEFAULT,
  localparam int SW       = $clog2(LOG2N),
  localparam int TW_W     = tw_width(LOG2N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             bf_valid,
  input  logic             bf_ready,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
`ifdef FFT_TW_QUARTER_EN
  output logic             tw_swap,
  output logic             tw_neg,
`endif
  output logic [TW_W-1:0]  tw_addr,
  output logic [SW-1:0]    stage
);

  localparam logic [LOG2N-2:0] J_LAST     = '1;
  localparam logic [SW-1:0]    S_LAST     = SW'(LOG2N - 1);
  localparam logic [3:0]       DRAIN_LOAD = 4'(BFLY_LAT);

  seq_state_t       state, state_n;
  logic [SW-1:0]    s, s_n;
  logic [LOG2N-2:0] j, j_n;
  logic [3:0]       drain, drain_n;
  logic [LOG2N-1:0] calc_a, calc_b;
  logic [TW_W-1:0]  calc_tw;
`ifdef FFT_TW_QUARTER_EN
  logic             calc_swap, calc_neg;
`endif

  // Addresses are computed from the next (s, j) so they register alongside the state.
  fft_bf_addr_calc #(.LOG2N(LOG2N)) u_calc (
    .s       (s_n),
    .j       (j_n),
    .addr_a  (calc_a),
    .addr_b  (calc_b),
`ifdef FFT_TW_QUARTER_EN
    .tw_swap (calc_swap),
    .tw_neg  (calc_neg),
`endif
    .tw_addr (calc_tw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // abort overrides every transition; a stall only freezes j, never the drain countdown.
  always_comb begin
    state_n = state;
    s_n     = s;
    j_n     = j;
    drain_n = drain;
    if (abort) begin
      state_n = IDLE;
      s_n     = '0;
      j_n     = '0;
      drain_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_n = RUN;
            s_n     = '0;
            j_n     = '0;
          end
        end
        RUN: begin
          if (bf_ready) begin
            if (j == J_LAST) begin
              state_n = DRAIN;
              drain_n = DRAIN_LOAD;
            end else begin
              j_n = j + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain == 4'd1) begin
            drain_n = '0;
            if (s == S_LAST) begin
              state_n = DONE;
            end else begin
              state_n = RUN;
              s_n     = s + 1'b1;
              j_n     = '0;
            end
          end else begin
            drain_n = drain - 4'd1;
          end
        end
        DONE: begin
          state_n = IDLE;
          s_n     = '0;
          j_n     = '0;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state == RUN) || (state == DRAIN);
    done     = (state == DONE);
    bf_valid = (state == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s       <= '0;
      j       <= '0;
      drain   <= '0;
      addr_a  <= '0;
      addr_b  <= '0;
      tw_addr <= '0;
`ifdef FFT_TW_QUARTER_EN
      tw_swap <= 1'b0;
      tw_neg  <= 1'b0;
`endif
    end else begin
      s       <= s_n;
      j       <= j_n;
      drain   <= drain_n;
      addr_a  <= calc_a;
      addr_b  <= calc_b;
      tw_addr <= calc_tw;
`ifdef FFT_TW_QUARTER_EN
      tw_swap <= calc_swap;
      tw_neg  <= calc_neg;
`endif
    end
  end

  assign stage = s;

endmodule

// File: doc/fft_twiddle_sequencer.md
Name: fft_twiddle_sequencer

Overview:
Sequences one in-place radix-2 DIT FFT of 2^LOG2N points, stage by stage.
- Per butterfly: emits data-RAM read addresses for operands A/B and the twiddle ROM address (ROM holds 2^(LOG2N-1) entries).
- Sits between the FFT top-level control and the butterfly datapath; the datapath carries addresses through its pipeline for write-back.
- Inserts a drain gap between stages to avoid read-after-write hazards.

Parameters:
- LOG2N, 10, log2 of FFT size; stages = LOG2N, butterflies per stage = 2^(LOG2N-1).
- BFLY_LAT, 4, butterfly pipeline depth in cycles (read to write-back); drain length between stages; legal range 1..15.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin transform; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE next edge, no done.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse after the final stage drains.
- bf_valid  out  1  butterfly issue valid.
- bf_ready  in  1  datapath accepts issue when bf_valid & bf_ready.
- addr_a  out  LOG2N  operand A RAM address.
- addr_b  out  LOG2N  operand B RAM address.
- tw_addr  out  LOG2N-1  twiddle ROM address.
- stage  out  clog2(LOG2N)  current stage index.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy, done, bf_valid, addr_a, addr_b, tw_addr and stage all 0.
  - Counters j and drain cleared.
- States are IDLE, RUN, DRAIN and DONE.
- IDLE:
  - start=1 -> RUN with stage=0, j=0.
  - bf_valid asserts the cycle after start.
- RUN:
  - bf_valid=1; addresses are registered functions of (stage s, j).
  - half = 1<<s; k = j & (half-1); grp = j>>s.
  - addr_a = (grp<<(s+1)) | k; addr_b = addr_a + half.
  - tw_addr = k << (LOG2N-1-s), truncated to LOG2N-1 bits.
  - All arithmetic is unsigned, with no overflow by construction.
  - Handshake: j increments only on bf_valid & bf_ready. With bf_ready=0, outputs hold stable and bf_valid stays high.
  - On acceptance with j = 2^(LOG2N-1)-1 -> DRAIN, drain=BFLY_LAT, bf_valid=0 from the next cycle.
- DRAIN:
  - Counts down exactly BFLY_LAT cycles, independent of bf_ready.
  - At expiry: if s = LOG2N-1 -> DONE; else s++, j=0 -> RUN.
- DONE:
  - done=1 for one cycle, busy=0 -> IDLE.
  - start in DONE is ignored; the earliest restart is the cycle after returning to IDLE.
- start while busy: ignored.
- abort has priority over all transitions and over start. From any state it goes to IDLE, clears counters and drops bf_valid/busy. No done pulse.
- Throughput with bf_ready always 1: one butterfly per cycle.
  - Total = LOG2N*(2^(LOG2N-1)+BFLY_LAT) cycles from the first valid to the last drain cycle.
  - done follows in the next cycle.

Optional Feature:
- Macro: FFT_TW_QUARTER_EN.
- Defined: twiddle ROM holds only a quarter wave (2^(LOG2N-2) entries).
  - tw_addr narrows to LOG2N-2 bits.
  - Two extra outputs: tw_swap (1 = swap re/im) and tw_neg (1 = negate the swapped real part).
  - For full index t: tw_swap = t[LOG2N-2]; tw_addr = tw_swap ? t - 2^(LOG2N-2) : t.
  - If the remapped address equals 0 with tw_swap=1, the output is exact -j.
  - tw_swap/tw_neg are registered with the other addresses; both reset to 0.
- Undefined: full-half-wave tw_addr as above; no extra ports.

Decomposition:
- Shared package fft_pkg holds:
  - LOG2N and BFLY_LAT defaults.
  - The state enum {IDLE, RUN, DRAIN, DONE}.
  - STAGE_W = clog2(LOG2N).
  - NBF = 2^(LOG2N-1).
- One natural sub-module: fft_bf_addr_calc, a combinational (s, j) -> (addr_a, addr_b, tw_addr [, tw_swap, tw_neg]) mapper.
  - Registered in the parent, and reusable by the write-back side.

Test Plan:
1. Reset then start, bf_ready=1, LOG2N=10, BFLY_LAT=4 -> stage0 j0: a=0, b=1, tw=0; j1: a=2, b=3, tw=0. done pulses exactly 5161 cycles after the start edge, busy high cycles 1..5160.
2. Stage 3, j=13 -> a=21, b=29, tw=320. Stage 9, j=5 -> a=5, b=517, tw=5. Stage 9, j=511 -> a=511, b=1023, tw=511.
3. Random bf_ready deassertion (~30%) -> no skipped or duplicated (s, j). Outputs stable while stalled. Exactly 5120 accepted issues, and each stage's addresses cover 0..1023 exactly once.
4. abort mid-stage 4 with start held high simultaneously -> IDLE next edge, bf_valid=0, no done. A start two cycles later restarts from stage 0, j=0.
5. start pulses while busy and during DONE -> ignored; exactly one done per accepted start. Async rst_n low mid-DRAIN -> all outputs 0 immediately.
6. FFT_TW_QUARTER_EN defined, stage 9, j=300 -> tw_swap=1, tw_addr=44. j=256 -> tw_swap=1, tw_addr=0. j=255 -> tw_swap=0, tw_addr=255.
